// File: rtl/alu_opsel_pipe.sv
// alu_opsel_pipe: two-stage operand-select / add pipeline.
// Stage 1 captures a, the op-conditioned operand m, the carry-in and the
// operand-A source. Stage 2 adds through a ripple chain of bit slices and
// registers the result, carry-out, signed overflow and zero flag.
// Valid/ready on both sides. There is no skid buffer, so in_ready is a
// combinational function of the stage state and out_ready.

// One full-adder slice of the stage-2 ripple chain.
module alu_opsel_bit (
   input  logic x,
   input  logic m,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ m ^ ci;
   assign co = (x & m) | (ci & (x ^ m));
endmodule

module alu_opsel_pipe #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         s1,
   input  logic         s0,
   input  logic         acc_sel,
   input  logic         acc_clr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] o,
   output logic         cout,
   output logic         ovf,
   output logic         zero
);

   localparam int STAGES = 2;

   // Op encodings on {s1,s0}.
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_INC = 2'b10;
   localparam logic [1:0] OP_DEC = 2'b11;

   // Request held in stage 1: everything stage 2 needs to finish the add.
   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] m;
      logic         cin;
      logic         acc_sel;
   } s1_req_t;

   // Registered response presented to the write-back stage.
   typedef struct packed {
      logic [W-1:0] o;
      logic         cout;
      logic         ovf;
      logic         zero;
   } s2_rsp_t;

   // vld_pipe[1] = stage-1 occupied, vld_pipe[2] = output valid.
   logic [STAGES:1] vld_pipe;
   logic            accept;
   logic            adv;

   s1_req_t         req_d;
   s1_req_t         s1_q;
   s2_rsp_t         rsp_d;
   s2_rsp_t         s2_q;

   logic [W-1:0]    acc;
   logic [W-1:0]    x;
   logic [W-1:0]    sum;
   logic [W:0]      carry;

   // ------------------------------------------------------------------
   // Handshake. Stage 2 drains whenever its slot is free or being read
   // this cycle, so with out_ready held high one transaction per cycle
   // flows through.
   // ------------------------------------------------------------------
   assign adv      = vld_pipe[1] & (~vld_pipe[2] | out_ready);
   assign in_ready = ~vld_pipe[1] | adv;
   assign accept   = in_valid & in_ready;

   // Decode the op into the conditioned operand and its carry-in.
   always_comb begin
      req_d         = '0;
      req_d.a       = a;
      req_d.acc_sel = acc_sel;
      case ({s1, s0})
         OP_ADD: begin
            req_d.m   = b;
            req_d.cin = 1'b0;
         end
         OP_SUB: begin
            req_d.m   = ~b;
            req_d.cin = 1'b1;
         end
         OP_INC: begin
            req_d.m   = '0;
            req_d.cin = 1'b1;
         end
         OP_DEC: begin
            req_d.m   = '1;
            req_d.cin = 1'b0;
         end
         default: begin
            req_d.m   = b;
            req_d.cin = 1'b0;
         end
      endcase
   end

   // Track occupancy of both stages; a reset drops anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else begin
         if (accept)
            vld_pipe[1] <= 1'b1;
         else if (adv)
            vld_pipe[1] <= 1'b0;

         if (adv)
            vld_pipe[2] <= 1'b1;
         else if (out_ready)
            vld_pipe[2] <= 1'b0;
      end
   end

   // Stage-1 capture of the decoded request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         s1_q <= '0;
      else if (accept)
         s1_q <= req_d;
   end

   // ------------------------------------------------------------------
   // Stage 2 datapath. The accumulator always holds the last stage-2
   // result, so a back-to-back acc_sel op sees its predecessor directly
   // without any forwarding path.
   // ------------------------------------------------------------------
   assign x        = s1_q.acc_sel ? acc : s1_q.a;
   assign carry[0] = s1_q.cin;

   for (genvar i = 0; i < W; i++) begin : g_bit
      alu_opsel_bit u_bit (
         .x  (x[i]),
         .m  (s1_q.m[i]),
         .ci (carry[i]),
         .s  (sum[i]),
         .co (carry[i+1])
      );
   end

   // Build the response word and flags from the adder outputs.
   always_comb begin
      rsp_d      = '0;
      rsp_d.o    = sum;
      rsp_d.cout = carry[W];
      rsp_d.ovf  = (x[W-1] == s1_q.m[W-1]) & (sum[W-1] != x[W-1]);
      rsp_d.zero = (sum == '0);
   end

   // Result register: loads on advance only, so it holds through stalls
   // and keeps its last value after the consumer drains it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         s2_q <= '0;
      else if (adv)
         s2_q <= rsp_d;
   end

   // Accumulator update; a clear beats a simultaneous load, while the
   // add in that same cycle has already used the pre-clear value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (acc_clr)
         acc <= '0;
      else if (adv)
         acc <= sum;
   end

   assign out_valid = vld_pipe[2];
   assign o         = s2_q.o;
   assign cout      = s2_q.cout;
   assign ovf       = s2_q.ovf;
   assign zero      = s2_q.zero;

endmodule

// File: doc/alu_opsel_pipe.md
Name: alu_opsel_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit ALU operand-select stage.
- Conditions operand b by 2-bit op (add/sub/inc/dec) and generates the matching carry-in.
- Adds the conditioned operand to a (or to an internal accumulator), registers result plus flags.
- Valid/ready handshake on both sides; sits between the register-file read and the write-back stage.

Parameters:
- W, 4, datapath width in bits (W >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input this cycle.
- a  in  W  operand A, unsigned/two's complement.
- b  in  W  operand B.
- s1  in  1  op select MSB.
- s0  in  1  op select LSB.
- acc_sel  in  1  1: use accumulator instead of a.
- acc_clr  in  1  synchronous accumulator clear.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- o  out  W  result.
- cout  out  1  adder carry-out.
- ovf  out  1  signed overflow.
- zero  out  1  o == 0.

Behaviour:
- Reset (rst_n low, async): out_valid=0, o=0, cout=0, ovf=0, zero=0, stage-1 valid=0, accumulator=0. in_ready=1 once stage 1 is empty.
- Op decode, conditioned operand m and carry-in cin:
  - s1s0=00 ADD: m=b, cin=0.
  - 01 SUB: m=~b, cin=1.
  - 10 INC: m=0, cin=1.
  - 11 DEC: m=all ones, cin=0.
- Stage 1:
  - Input accepted on a rising edge when in_valid & in_ready.
  - Registers a, m, cin, acc_sel.
  - Stage-1 valid is set on accept and cleared on advance.
- Advance: adv = s1_valid & (~out_valid | out_ready).
- in_ready = ~s1_valid | adv (combinational, no skid). Gives full throughput: one transaction per cycle when out_ready=1.
- Stage 2 on adv:
  - x = acc_sel ? acc : a.
  - {cout,o} = x + m + cin, computed W+1 bits wide.
  - ovf = (x[W-1] == m[W-1]) & (o[W-1] != x[W-1]).
  - zero = (o == 0).
  - out_valid <= 1.
  - acc <= o.
- Output: if out_valid & out_ready & ~adv, then out_valid <= 0. o and flags hold their last value; they are not cleared.
- Stalls: while out_valid & ~out_ready, o, cout, ovf and zero are held stable.
- Latency: a transaction accepted at edge k has its result visible after edge k+1 when unstalled. That is two register stages.
- Accumulator:
  - Always holds the result of the most recent stage-2 load, so there is no forwarding hazard.
  - acc_clr=1 on an edge sets acc=0.
  - If acc_clr coincides with adv, the stage-2 computation uses the pre-clear acc, and the clear wins the acc write.
- Wrap-around: modulo 2^W. INC of all ones gives 0 with cout=1. DEC of 0 gives all ones with cout=0.
- Reset mid-operation: in-flight transactions are dropped and no output is produced for them.

Test Plan:
1. W=4, ADD a=0101 b=0011, out_ready=1 -> o=1000, cout=0, ovf=1, zero=0; out_valid rises exactly 2 edges after accept.
2. SUB a=0011 b=0011 -> o=0000, cout=1, ovf=0, zero=1. SUB a=0000 b=0001 -> o=1111, cout=0.
3. INC a=1111 -> o=0000, cout=1, zero=1. DEC a=0000 -> o=1111, cout=0, ovf=0. DEC a=1000 -> o=0111, ovf=1.
4. After reset, three back-to-back INC with acc_sel=1 -> o sequence 0001, 0010, 0011 on consecutive cycles. Then acc_clr pulse, then INC acc_sel=1 -> 0001.
5. Backpressure: out_ready=0, stream four ADDs of b=1..4, a=0 -> in_ready low after two accepts. Release out_ready -> outputs 0001..0100 in order, none lost or duplicated, o stable while stalled.
6. Assert rst_n=0 with both stages full -> out_valid=0 and o=0 immediately (async). No stale result after rst_n rises. First new transaction behaves as in test 1.
